ucode_fetch: RTL and testbench

Microcode fetch unit for the NPU. On a start pulse from the control-register block it reads `len` 64-bit microcode words from DDR, beginning at `base`, over the AXI4 read channel. It buffers the words in an internal FIFO and presents them in order to the microcode controller through a valid/ready instruction stream. It sits between the control registers (start, `ucode_base`, `ucode_len`) and the microcode controller, and owns the DDR AR/R channels.

---
 rtl/ucode_fetch.sv | 156 +++++++++++++++
 tb/tb_ucode_fetch.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ucode_fetch.sv
// Microcode fetch unit: reads a block of 64-bit words from DDR over AXI4 read bursts
// and streams them, in order, to the microcode controller through a show-ahead FIFO.
module ucode_fetch #(
    parameter int unsigned BURST_LEN  = 16,
    parameter int unsigned FIFO_DEPTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [31:0] i_base_addr,
    input  logic [31:0] i_len_words,
    output logic [31:0] o_m_axi_araddr,
    output logic [7:0]  o_m_axi_arlen,
    output logic [2:0]  o_m_axi_arsize,
    output logic        o_m_axi_arvalid,
    input  logic        i_m_axi_arready,
    input  logic [63:0] i_m_axi_rdata,
    input  logic        i_m_axi_rvalid,
    output logic        o_m_axi_rready,
    output logic [63:0] o_instr_data,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    output logic        o_busy,
    output logic        o_done
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StAddr, StData, StDrain} state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic [31:0]     r_addr;
    logic [31:0]     r_remaining;
    logic [8:0]      r_beat_cnt;
    logic            r_done;
    logic [63:0]     r_mem [FIFO_DEPTH];
    logic [PtrW-1:0] r_wr_ptr;
    logic [PtrW-1:0] r_rd_ptr;
    logic [CntW-1:0] r_count;

    logic [31:0] w_page_beats;
    logic [31:0] w_beats32;
    logic [31:0] w_free;
    logic [8:0]  w_beats;
    logic [8:0]  w_arlen;
    logic        w_space_ok;
    logic        w_ar_fire;
    logic        w_push;
    logic        w_pop;
    logic        w_last_beat;

    // Burst length: limited by words left, max burst, and the distance to the next 4 KB page.
    always_comb begin
        w_page_beats = (32'd4096 - {20'd0, r_addr[11:0]}) >> 3;
        w_beats32    = r_remaining;
        if (w_beats32 > 32'(BURST_LEN)) begin
            w_beats32 = 32'(BURST_LEN);
        end
        if (w_beats32 > w_page_beats) begin
            w_beats32 = w_page_beats;
        end
    end

    assign w_beats    = w_beats32[8:0];
    assign w_arlen    = w_beats - 9'd1;
    assign w_free     = 32'(FIFO_DEPTH) - 32'(r_count);
    // Space is reserved for the whole burst before it is requested, so pushes never overflow.
    assign w_space_ok = w_free >= w_beats32;

    assign o_m_axi_arvalid = (r_state == StAddr) && w_space_ok;
    assign o_m_axi_araddr  = (r_state == StAddr) ? r_addr : 32'd0;
    assign o_m_axi_arlen   = (r_state == StAddr) ? w_arlen[7:0] : 8'd0;
    assign o_m_axi_arsize  = (r_state == StAddr) ? 3'b011 : 3'b000;
    assign o_m_axi_rready  = (r_state == StData);

    assign w_ar_fire   = o_m_axi_arvalid && i_m_axi_arready;
    assign w_push      = o_m_axi_rready && i_m_axi_rvalid;
    assign w_pop       = o_instr_valid && i_instr_ready;
    assign w_last_beat = w_push && (r_beat_cnt == 9'd1);

    assign o_instr_valid = (r_count != '0);
    assign o_instr_data  = o_instr_valid ? r_mem[r_rd_ptr] : 64'd0;
    assign o_busy        = (r_state != StIdle);
    assign o_done        = r_done;

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_next = (i_len_words == 32'd0) ? StDrain : StAddr;
                end
            end
            StAddr: begin
                if (w_ar_fire) begin
                    w_state_next = StData;
                end
            end
            StData: begin
                if (w_last_beat) begin
                    w_state_next = (r_remaining != 32'd0) ? StAddr : StDrain;
                end
            end
            StDrain: begin
                if (r_count == '0) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_addr      <= 32'd0;
            r_remaining <= 32'd0;
            r_beat_cnt  <= 9'd0;
            r_done      <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
        end else begin
            r_state <= w_state_next;
            r_done  <= (r_state == StDrain) && (r_count == '0);
            if ((r_state == StIdle) && i_start) begin
                r_addr      <= {i_base_addr[31:3], 3'b000};
                r_remaining <= i_len_words;
            end
            if (w_ar_fire) begin
                r_addr      <= r_addr + {20'd0, w_beats, 3'b000};
                r_remaining <= r_remaining - w_beats32;
                r_beat_cnt  <= w_beats;
            end else if (w_push) begin
                r_beat_cnt <= r_beat_cnt - 9'd1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
            r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_m_axi_rdata;
        end
    end

endmodule

// File: tb/tb_ucode_fetch.sv
// Bench for ucode_fetch: random AXI/consumer stalls against a DDR responder and a
// transaction-level model of the expected burst list, word stream and done timing.
module tb_ucode_fetch;

    localparam int unsigned BurstLen  = 16;
    localparam int unsigned FifoDepth = 32;

    typedef struct {
        logic [31:0] addr;
        int unsigned n;
    } ar_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [31:0] i_base_addr = 32'd0;
    logic [31:0] i_len_words = 32'd0;
    logic [31:0] o_m_axi_araddr;
    logic [7:0]  o_m_axi_arlen;
    logic [2:0]  o_m_axi_arsize;
    logic        o_m_axi_arvalid;
    logic        i_m_axi_arready = 1'b0;
    logic [63:0] i_m_axi_rdata = 64'd0;
    logic        i_m_axi_rvalid = 1'b0;
    logic        o_m_axi_rready;
    logic [63:0] o_instr_data;
    logic        o_instr_valid;
    logic        i_instr_ready = 1'b0;
    logic        o_busy;
    logic        o_done;

    ucode_fetch #(.BURST_LEN(BurstLen), .FIFO_DEPTH(FifoDepth)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_start        (i_start),
        .i_base_addr    (i_base_addr),
        .i_len_words    (i_len_words),
        .o_m_axi_araddr (o_m_axi_araddr),
        .o_m_axi_arlen  (o_m_axi_arlen),
        .o_m_axi_arsize (o_m_axi_arsize),
        .o_m_axi_arvalid(o_m_axi_arvalid),
        .i_m_axi_arready(i_m_axi_arready),
        .i_m_axi_rdata  (i_m_axi_rdata),
        .i_m_axi_rvalid (i_m_axi_rvalid),
        .o_m_axi_rready (o_m_axi_rready),
        .o_instr_data   (o_instr_data),
        .o_instr_valid  (o_instr_valid),
        .i_instr_ready  (i_instr_ready),
        .o_busy         (o_busy),
        .o_done         (o_done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model state
    logic [63:0] exp_q[$];
    ar_t         ar_q[$];
    ar_t         ar_log[$];
    int          occ = 0;
    int unsigned pushed = 0;
    int unsigned popped = 0;
    int unsigned m_len = 0;
    bit          m_active = 0;
    bit          m_done_exp = 0;
    logic [31:0] s_addr = 32'd0;
    int unsigned s_left = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          done_cyc = 0;
    int          done_cnt = 0;
    int unsigned ar_pct = 100;
    int unsigned r_pct = 100;
    int unsigned rdy_pct = 100;

    function automatic logic [63:0] ddr_word(input logic [31:0] a);
        return {a ^ 32'hA5C3_0F96, (a * 32'd2654435761) ^ 32'h1234_5678};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // DDR responder and consumer: randomized handshakes, data from the DDR model.
    always @(posedge clk) begin
        #1;
        i_m_axi_arready = ($urandom_range(99) < ar_pct);
        i_m_axi_rvalid  = (s_left > 0) && ($urandom_range(99) < r_pct);
        i_m_axi_rdata   = i_m_axi_rvalid ? ddr_word(s_addr) : {$urandom, $urandom};
        i_instr_ready   = ($urandom_range(99) < rdy_pct);
    end

    // Compare process: outputs are checked every cycle, then this cycle's handshakes are
    // applied to the model ahead of the next rising edge.
    always @(negedge clk) begin
        bit          was_active;
        bit          exp_arv;
        bit          next_done;
        logic [31:0] a;
        int unsigned rem;
        int unsigned b;
        int unsigned pg;
        if (!rst_n) begin
            exp_q.delete();
            ar_q.delete();
            occ        = 0;
            pushed     = 0;
            m_len      = 0;
            m_active   = 0;
            m_done_exp = 0;
            s_left     = 0;
        end else begin
            was_active = m_active;
            chk("busy", 64'(o_busy), 64'(m_active));
            chk("done", 64'(o_done), 64'(m_done_exp));
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            chk("instr_valid", 64'(o_instr_valid), 64'(occ > 0));
            if (occ > 0) begin
                if (exp_q.size() > 0) chk("instr_data", o_instr_data, exp_q[0]);
                else chk("instr_extra_word", 64'(o_instr_valid), 64'd0);
            end
            chk("rready", 64'(o_m_axi_rready), 64'(s_left > 0));
            exp_arv = 0;
            if (m_active && s_left == 0 && ar_q.size() > 0) begin
                exp_arv = (FifoDepth - occ) >= ar_q[0].n;
            end
            chk("arvalid", 64'(o_m_axi_arvalid), 64'(exp_arv));
            if (o_m_axi_arvalid && ar_q.size() > 0) begin
                chk("araddr", 64'(o_m_axi_araddr), 64'(ar_q[0].addr));
                chk("arlen", 64'(o_m_axi_arlen), 64'(ar_q[0].n - 1));
                chk("arsize", 64'(o_m_axi_arsize), 64'd3);
            end

            next_done = m_active && (pushed == m_len) && (occ == 0);
            if (occ > 0 && i_instr_ready) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                occ--;
                popped++;
            end
            if (o_m_axi_rready && i_m_axi_rvalid) begin
                s_addr = s_addr + 32'd8;
                s_left--;
                pushed++;
                occ++;
                chk("fifo_bound", 64'(occ <= FifoDepth), 64'd1);
            end
            if (o_m_axi_arvalid && i_m_axi_arready) begin
                ar_log.push_back('{addr: o_m_axi_araddr, n: 32'(o_m_axi_arlen)});
                s_addr = o_m_axi_araddr;
                s_left = 32'(o_m_axi_arlen) + 1;
                if (ar_q.size() > 0) void'(ar_q.pop_front());
            end
            m_done_exp = next_done;
            if (next_done) m_active = 0;

            if (i_start && !was_active) begin
                m_active  = 1;
                m_len     = i_len_words;
                pushed    = 0;
                start_cyc = cyc;
                a = {i_base_addr[31:3], 3'b000};
                for (int unsigned i = 0; i < m_len; i++) exp_q.push_back(ddr_word(a + 32'(i * 8)));
                rem = m_len;
                while (rem > 0) begin
                    pg = (4096 - int'(a % 4096)) / 8;
                    b  = rem;
                    if (b > BurstLen) b = BurstLen;
                    if (b > pg) b = pg;
                    ar_q.push_back('{addr: a, n: b});
                    a   = a + 32'(b * 8);
                    rem = rem - b;
                end
            end
        end
        cyc++;
    end

    task automatic fetch(input logic [31:0] b, input logic [31:0] l);
        popped = 0;
        ar_log.delete();
        @(posedge clk);
        #1;
        i_start     = 1'b1;
        i_base_addr = b;
        i_len_words = l;
        @(posedge clk);
        #1;
        i_start     = 1'b0;
        i_base_addr = $urandom;
        i_len_words = $urandom;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        d0 = done_cnt;
        for (int k = 0; k < budget && done_cnt == d0; k++) @(posedge clk);
        chk("done_seen", 64'(done_cnt - d0), 64'd1);
        repeat (2) @(posedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_araddr"}, 64'(o_m_axi_araddr), 64'd0);
        chk({tag, "_arlen"}, 64'(o_m_axi_arlen), 64'd0);
        chk({tag, "_arsize"}, 64'(o_m_axi_arsize), 64'd0);
        chk({tag, "_arvalid"}, 64'(o_m_axi_arvalid), 64'd0);
        chk({tag, "_rready"}, 64'(o_m_axi_rready), 64'd0);
        chk({tag, "_instr_data"}, o_instr_data, 64'd0);
        chk({tag, "_instr_valid"}, 64'(o_instr_valid), 64'd0);
        chk({tag, "_busy"}, 64'(o_busy), 64'd0);
        chk({tag, "_done"}, 64'(o_done), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Single short burst
        fetch(32'h0000_1000, 32'd4);
        wait_done(200);
        chk("t1_ar_count", 64'(ar_log.size()), 64'd1);
        chk("t1_ar0_addr", 64'(ar_log[0].addr), 64'h1000);
        chk("t1_ar0_len", 64'(ar_log[0].n), 64'd3);
        chk("t1_words", 64'(popped), 64'd4);
        chk("t1_busy_after", 64'(o_busy), 64'd0);

        // Three bursts, last one short
        fetch(32'h0000_0000, 32'd40);
        wait_done(400);
        chk("t2_ar_count", 64'(ar_log.size()), 64'd3);
        chk("t2_ar0", {ar_log[0].addr, ar_log[0].n}, {32'h0, 32'd15});
        chk("t2_ar1", {ar_log[1].addr, ar_log[1].n}, {32'h80, 32'd15});
        chk("t2_ar2", {ar_log[2].addr, ar_log[2].n}, {32'h100, 32'd7});
        chk("t2_words", 64'(popped), 64'd40);

        // 4 KB boundary split
        fetch(32'h0000_0FF0, 32'd4);
        wait_done(200);
        chk("t3_ar_count", 64'(ar_log.size()), 64'd2);
        chk("t3_ar0", {ar_log[0].addr, ar_log[0].n}, {32'hFF0, 32'd1});
        chk("t3_ar1", {ar_log[1].addr, ar_log[1].n}, {32'h1000, 32'd1});

        // Consumer stalled: FIFO fills, third burst withheld
        rdy_pct = 0;
        fetch(32'h0000_4000, 32'd64);
        repeat (100) @(posedge clk);
        chk("t4_ar_withheld", 64'(ar_log.size()), 64'd2);
        chk("t4_full_valid", 64'(o_instr_valid), 64'd1);
        rdy_pct = 100;
        wait_done(500);
        chk("t4_ar_count", 64'(ar_log.size()), 64'd4);
        chk("t4_words", 64'(popped), 64'd64);

        // Zero-length fetch
        fetch(32'h0000_2000, 32'd0);
        wait_done(20);
        chk("t5_done_latency", 64'(done_cyc - start_cyc), 64'd2);
        chk("t5_no_ar", 64'(ar_log.size()), 64'd0);

        // Second start mid-fetch is ignored
        ar_pct = 70; r_pct = 70; rdy_pct = 70;
        fetch(32'h0000_2000, 32'd20);
        repeat (6) @(posedge clk);
        #1;
        i_start = 1'b1; i_base_addr = 32'h0000_9000; i_len_words = 32'd5;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        wait_done(1000);
        chk("t6_words", 64'(popped), 64'd20);

        // Reset mid-burst, then a fresh fetch
        fetch(32'h0000_6000, 32'd100);
        for (int k = 0; k < 200 && s_left == 0; k++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ar_pct = 100; r_pct = 100; rdy_pct = 100;
        fetch(32'h0000_3008, 32'd10);
        wait_done(300);
        chk("t7_words", 64'(popped), 64'd10);
        chk("t7_ar0_addr", 64'(ar_log[0].addr), 64'h3008);

        // Random stalls
        for (int t = 0; t < 5; t++) begin
            logic [31:0] b;
            logic [31:0] l;
            ar_pct  = $urandom_range(30, 90);
            r_pct   = $urandom_range(30, 90);
            rdy_pct = $urandom_range(30, 90);
            if (t == 0) begin
                b = 32'h0000_5F40; l = 32'd100;
            end else if (t == 1) begin
                b = 32'hFFFF_FF83; l = 32'd50;
            end else begin
                b = $urandom; l = $urandom_range(1, 100);
            end
            fetch(b, l);
            wait_done(5000);
            chk("t8_words", 64'(popped), 64'(l));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
